// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_add.sv
// Combinational 1-bit full adder used as the per-bit step of the serial adder.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | ((a ^ b) & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first,
// operands and result exchanged over valid/ready handshakes.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_c;
    logic             w_last;

    full_add u_full_add (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_carry),
        .sum   (w_s),
        .carry (w_c)
    );

    assign w_last    = (r_cnt == LAST_BIT);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum_sr;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_a_sr  <= a;
                r_b_sr  <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end
        end else if (r_state == RUN) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_carry  <= w_c;
            r_cnt    <= r_cnt + 1'b1;
            // On the MSB step r_carry is the carry into the MSB, w_c the carry out.
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with hand-computed expected results.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the operand inputs after the accept edge,
    // measure latency, optionally hold off out_ready, then release.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tcin, input logic [WIDTH-1:0] e_sum,
                          input logic e_cout, input logic e_ovf, input int hold);
        int lat;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tcin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_;
        cin = ~tcin;
        lat = 0;
        for (int i = 1; i <= 3 * WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, WIDTH);
        check("sum", sum, e_sum);
        check("cout", cout, e_cout);
        check("ovf", ovf, e_ovf);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 8'h11;
            b = 8'h22;
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, e_sum);
            check("hold_flags", {cout, ovf}, {e_cout, e_ovf});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_fall", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");

        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 5);

        // Abort in the middle of RUN: state left over from the previous op must clear.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
